// File: rtl/calc_sequencer.sv
// Control sequencer for the calculator add/sub datapath: captures A, B and the
// operation on enter presses, waits for the datapath to settle, then holds the result.
module calc_sequencer #(
    parameter int n      = 6,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] din,
    input  logic         op_sel,
    input  logic         btn_enter,
    input  logic         btn_clear,
    input  logic [n-1:0] res,
    output logic [n-1:0] op_a,
    output logic [n-1:0] op_b,
    output logic         sub_en,
    output logic [n-1:0] result,
    output logic         done,
    output logic         zero,
    output logic [2:0]   state_out
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_WAIT = 3'd2,
        S_SHOW = 3'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state;
    logic       btn_prev;
    logic [3:0] cnt;
    logic       enter_pulse;

    assign enter_pulse = btn_enter & ~btn_prev;
    assign state_out   = state;

    // btn_prev resets high so a button held through reset release cannot fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_A;
            btn_prev <= 1'b1;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            sub_en   <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
            zero     <= 1'b0;
        end else begin
            btn_prev <= btn_enter;
            if (btn_clear) begin
                state  <= S_A;
                cnt    <= '0;
                op_a   <= '0;
                op_b   <= '0;
                sub_en <= 1'b0;
                result <= '0;
                done   <= 1'b0;
                zero   <= 1'b0;
            end else begin
                case (state)
                    S_A: begin
                        if (enter_pulse) begin
                            op_a  <= din;
                            state <= S_B;
                        end
                    end
                    S_B: begin
                        if (enter_pulse) begin
                            op_b   <= din;
                            sub_en <= op_sel;
                            cnt    <= CNT_INIT;
                            state  <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        // enter presses here are dropped, not queued
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            result <= res;
                            zero   <= (res == '0);
                            done   <= 1'b1;
                            state  <= S_SHOW;
                        end
                    end
                    S_SHOW: begin
                        if (enter_pulse) begin
                            op_a  <= result;
                            done  <= 1'b0;
                            zero  <= 1'b0;
                            state <= S_B;
                        end
                    end
                    default: state <= S_A;
                endcase
            end
        end
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Control FSM for the calculator's add/sub datapath.
- Captures operand A, operand B and the operation from switch inputs on successive rising edges of the enter button.
- Drives the operand buses and the add/sub result-select line, waits a fixed settle time, then registers the selected result for display.
- Supports chained calculation: the last result becomes the next operand A.

Parameters:
- n, 6, datapath width of operands and result.
- SETTLE, 2, clock cycles the datapath is given to settle before the result is captured; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- din  input  n  operand value from switches
- op_sel  input  1  operation request; 0 = add, 1 = subtract
- btn_enter  input  1  enter button; debounced and synchronised upstream, level signal
- btn_clear  input  1  clear button; level signal, synchronous clear
- res  input  n  selected datapath result (output of the result selector)
- op_a  output  n  operand A to adder and subtractor
- op_b  output  n  operand B to adder and subtractor
- sub_en  output  1  result-select line; 1 selects the subtract result
- result  output  n  registered result for display
- done  output  1  high while a valid result is held
- zero  output  1  high when result == 0 and done == 1
- state_out  output  3  current state code for LEDs

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = S_A; op_a, op_b, result = 0; sub_en = 0; done = 0; zero = 0.
  - Edge-detect register = 1, so a button held through reset release does not fire.
  - Settle counter = 0.
- Enter edge: enter_pulse = btn_enter & ~btn_prev, where btn_prev is btn_enter registered every clk.
  - A held button produces exactly one pulse.
- State codes: S_A = 0, S_B = 1, S_WAIT = 2, S_SHOW = 3. Codes 4–7 are unused; any unused code goes to S_A on the next clk.
- Transitions, all registered on clk:
  - S_A: on enter_pulse, op_a <= din; go to S_B.
  - S_B: on enter_pulse, op_b <= din, sub_en <= op_sel, cnt <= SETTLE-1; go to S_WAIT.
  - S_WAIT: if cnt != 0, cnt <= cnt-1. If cnt == 0, result <= res, done <= 1; go to S_SHOW.
  - S_SHOW: on enter_pulse, op_a <= result, done <= 0; go to S_B (chain).
- Latency: if the B-enter pulse is sampled at edge k, result is captured at edge k+SETTLE. done rises after edge k+SETTLE.
- Input sampling:
  - din and op_sel are ignored except on the capturing pulse.
  - op_sel changes after capture do not affect sub_en.
  - enter_pulse in S_WAIT is ignored. No queueing.
- Output stability:
  - op_a, op_b and sub_en are stable throughout S_WAIT and S_SHOW.
  - result holds its value until the next capture or clear.
- Arithmetic: the block does not compute. Wrap-around is whatever res carries, modulo 2^n; result is captured bit-exact.
- zero is registered together with result: zero <= (res == 0) at capture; cleared with done.
- btn_clear (synchronous):
  - In any state: state <= S_A; op_a, op_b, result <= 0; sub_en, done, zero <= 0; cnt <= 0.
  - Clear has priority over a simultaneous enter_pulse. btn_prev still updates.
- Asynchronous reset mid-operation (including in S_WAIT) forces reset values immediately. No partial capture.
- state_out = current state code.

Test Plan:
- Reset, then din = 5 with enter pulse, then din = 3 with op_sel = 0 and enter pulse; res model = op_a + op_b -> sub_en = 0; result = 8 exactly SETTLE (2) edges after the B pulse; done = 1; zero = 0; state_out = 3.
- A = 5, B = 3, op_sel = 1, res model = op_a - op_b -> sub_en = 1; result = 2. Then A = 3, B = 5, subtract -> result = 62 (wrap, n = 6).
- A = 60, B = 10, add -> result = 6 (70 mod 64). A = 7, B = 7, subtract -> result = 0, zero = 1.
- Chain: after result = 8, enter pulse -> op_a = 8, done = 0, state S_B. Then B = 4, add -> result = 12.
- btn_enter held high for 20 cycles in S_A -> exactly one capture; state S_B, not S_WAIT. Toggle din and op_sel during S_WAIT and pulse enter -> result and sub_en unchanged.
- btn_clear asserted in S_WAIT together with an enter pulse -> next state S_A, all outputs 0, no result captured. rst_n pulsed low mid-S_WAIT -> outputs 0 immediately, before the next clk edge.
